// File: rtl/counter_sequencer.sv
// Run controller for a prescaled event counter: start/pause/resume, clear, preload and
// terminal-count detection, in one-shot or auto-reload mode, with one-cycle tick/done strobes.
module counter_sequencer #(
   parameter int unsigned CLK_DIV    = 50000000,
   parameter int unsigned PRESCALE_W = 26,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic [CNT_W-1:0] i_limit,
   input  logic             i_auto_reload,
   output logic [CNT_W-1:0] o_cout,
   output logic             o_tick,
   output logic             o_done,
   output logic             o_busy,
   output logic [1:0]       o_state
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StPause = 2'b10,
      StDone  = 2'b11
   } state_e;

   localparam logic [PRESCALE_W-1:0] PresLast = PRESCALE_W'(CLK_DIV - 1);

   state_e                r_state;
   state_e                w_state_d;
   logic [CNT_W-1:0]      r_cout;
   logic [CNT_W-1:0]      w_cout_d;
   logic [PRESCALE_W-1:0] r_presc;
   logic [PRESCALE_W-1:0] w_presc_d;
   logic                  r_tick;
   logic                  w_tick_d;
   logic                  r_done;
   logic                  w_done_d;
   logic                  r_busy;

   logic [CNT_W-1:0]      w_step_val;
   logic                  w_step_hit;
   logic                  w_presc_last;

   // Value the counter takes on a step; auto-reload wraps to zero once the limit was reached.
   assign w_step_val   = (i_auto_reload && (r_cout == i_limit)) ? '0 : r_cout + CNT_W'(1);
   assign w_step_hit   = (w_step_val == i_limit);
   assign w_presc_last = (r_presc == PresLast);

   always_comb begin
      w_state_d = r_state;
      w_cout_d  = r_cout;
      w_presc_d = r_presc;
      w_tick_d  = 1'b0;
      w_done_d  = 1'b0;

      if (i_clear) begin
         w_state_d = StIdle;
         w_cout_d  = '0;
         w_presc_d = '0;
      end else if (i_load && (r_state != StRun)) begin
         w_cout_d = i_load_val;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  w_state_d = StRun;
                  w_presc_d = '0;
               end
            end
            StRun: begin
               // A pause freezes the prescaler even at expiry, so no step is lost or doubled.
               if (i_stop) begin
                  w_state_d = StPause;
               end else if (w_presc_last) begin
                  w_presc_d = '0;
                  w_tick_d  = 1'b1;
                  w_cout_d  = w_step_val;
                  if (w_step_hit) begin
                     w_done_d = 1'b1;
                     if (!i_auto_reload) begin
                        w_state_d = StDone;
                     end
                  end
               end else begin
                  w_presc_d = r_presc + PRESCALE_W'(1);
               end
            end
            StPause: begin
               if (i_start) begin
                  w_state_d = StRun;
               end
            end
            StDone: begin
               if (i_start) begin
                  w_state_d = StRun;
                  w_cout_d  = '0;
                  w_presc_d = '0;
               end
            end
            default: begin
               w_state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_cout  <= '0;
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cout  <= w_cout_d;
         r_presc <= w_presc_d;
         r_tick  <= w_tick_d;
         r_done  <= w_done_d;
         r_busy  <= (w_state_d == StRun);
      end
   end

   assign o_cout  = r_cout;
   assign o_tick  = r_tick;
   assign o_done  = r_done;
   assign o_busy  = r_busy;
   assign o_state = r_state;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: a behavioural model predicts every cycle's outputs,
// a separate monitor pops and compares them.
module tb_counter_sequencer;

   localparam int unsigned ClkDiv = 4;
   localparam int unsigned PresW  = 3;
   localparam int unsigned CntW   = 8;

   localparam int MIdle  = 0;
   localparam int MRun   = 1;
   localparam int MPause = 2;
   localparam int MDone  = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            stop = 1'b0;
   logic            clear = 1'b0;
   logic            load = 1'b0;
   logic [CntW-1:0] load_val = '0;
   logic [CntW-1:0] limit = '0;
   logic            auto_reload = 1'b0;
   logic [CntW-1:0] cout;
   logic            tick;
   logic            done;
   logic            busy;
   logic [1:0]      state;

   counter_sequencer #(
      .CLK_DIV   (ClkDiv),
      .PRESCALE_W(PresW),
      .CNT_W     (CntW)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_stop       (stop),
      .i_clear      (clear),
      .i_load       (load),
      .i_load_val   (load_val),
      .i_limit      (limit),
      .i_auto_reload(auto_reload),
      .o_cout       (cout),
      .o_tick       (tick),
      .o_done       (done),
      .o_busy       (busy),
      .o_state      (state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]      st;
      logic [CntW-1:0] cnt;
      logic            tck;
      logic            dn;
      logic            bsy;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: run mode, count value and cycles elapsed in the current count period.
   int m_mode  = MIdle;
   int m_cnt   = 0;
   int m_phase = 0;
   bit m_tick  = 1'b0;
   bit m_done  = 1'b0;

   task automatic check_obs(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got state=%0d cout=%0d tick=%0d done=%0d busy=%0d, want state=%0d cout=%0d tick=%0d done=%0d busy=%0d",
                  name, $time, act.st, act.cnt, act.tck, act.dn, act.bsy,
                  exp.st, exp.cnt, exp.tck, exp.dn, exp.bsy);
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
      end
   endtask

   function automatic obs_t dut_obs();
      obs_t o;
      o.st  = state;
      o.cnt = cout;
      o.tck = tick;
      o.dn  = done;
      o.bsy = busy;
      return o;
   endfunction

   task automatic model_reset();
      m_mode  = MIdle;
      m_cnt   = 0;
      m_phase = 0;
      m_tick  = 1'b0;
      m_done  = 1'b0;
   endtask

   // Called at a falling edge: applies commands, predicts the next edge, then waits one cycle.
   task automatic drive(input bit c, input bit l, input bit sp, input bit st,
                        input logic [CntW-1:0] lv);
      obs_t e;
      clear    = c;
      load     = l;
      stop     = sp;
      start    = st;
      load_val = lv;
      m_tick   = 1'b0;
      m_done   = 1'b0;
      if (c) begin
         m_mode  = MIdle;
         m_cnt   = 0;
         m_phase = 0;
      end else if (l && m_mode != MRun) begin
         m_cnt = int'(lv);
      end else if (m_mode == MRun) begin
         if (sp) begin
            m_mode = MPause;
         end else begin
            m_phase++;
            if (m_phase == ClkDiv) begin
               m_phase = 0;
               m_tick  = 1'b1;
               if (auto_reload && m_cnt == int'(limit)) m_cnt = 0;
               else m_cnt = (m_cnt + 1) % (1 << CntW);
               if (m_cnt == int'(limit)) begin
                  m_done = 1'b1;
                  if (!auto_reload) m_mode = MDone;
               end
            end
         end
      end else if (st) begin
         if (m_mode != MPause) m_phase = 0;
         if (m_mode == MDone) m_cnt = 0;
         m_mode = MRun;
      end
      e.st  = 2'(m_mode);
      e.cnt = CntW'(m_cnt);
      e.tck = m_tick;
      e.dn  = m_done;
      e.bsy = (m_mode == MRun);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, load_val);
   endtask

   initial begin : monitor
      obs_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_obs("cycle", dut_obs(), e);
         end
      end
   end

   initial begin : stimulus
      int guard;
      #1;
      check_obs("reset_state", dut_obs(), '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // One-shot to limit 3.
      limit = 8'd3;
      auto_reload = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      idle(14);
      check_val("oneshot_cout", int'(cout), 3);
      check_val("oneshot_state", int'(state), MDone);
      idle(40);

      // Auto-reload with limit 2.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      limit = 8'd2;
      auto_reload = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      idle(40);
      check_val("autoreload_busy", int'(busy), 1);

      // Pause and resume with the prescaler held part-way.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      limit = 8'd10;
      auto_reload = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      idle(6);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      check_val("pause_state", int'(state), MPause);
      idle(10);
      check_val("pause_hold", int'(cout), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      idle(2);
      check_val("resume_tick", int'(tick), 1);
      check_val("resume_cout", int'(cout), 2);

      // Preload above the limit wraps through zero.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      limit = 8'h01;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFE);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFE);
      idle(14);
      check_val("wrap_cout", int'(cout), 1);
      check_val("wrap_state", int'(state), MDone);

      // Command priority.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      limit = 8'd50;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      idle(5);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h33);
      check_val("prio_clear_state", int'(state), MIdle);
      check_val("prio_clear_cout", int'(cout), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      idle(5);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
      check_val("prio_stop_state", int'(state), MPause);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      idle(2);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
      idle(3);

      // Asynchronous reset mid-run at cout == 5.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      limit = 8'd20;
      auto_reload = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      guard = 0;
      while (m_cnt != 5 && guard < 100) begin
         idle(1);
         guard++;
      end
      check_val("reset_reach5", m_cnt, 5);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_obs("async_reset", dut_obs(), '0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      idle(4);
      check_val("restart_tick", int'(tick), 1);
      check_val("restart_cout", int'(cout), 1);

      // One-shot with limit 0 from 0 needs a full 2^CNT_W steps.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      limit = 8'd0;
      auto_reload = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      idle(1020);
      check_val("full_wrap_running", int'(state), MRun);
      idle(10);
      check_val("full_wrap_done", int'(state), MDone);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            if ($urandom_range(0, 3) == 0) limit = CntW'($urandom_range(0, 255));
            else limit = CntW'($urandom_range(0, 6));
         end
         if ($urandom_range(0, 79) == 0) auto_reload = ~auto_reload;
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
               CntW'($urandom_range(0, 255)));
      end
      idle(2);
      @(posedge clk);
      #3;
      check_val("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
